apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Round-robin arbiter sharing one APB slave port (e.g. padframe or hyper config target) between NUM_MASTERS APB requesters in the SoC clock domain.
- Latches the winner's request, replays it as a standard APB setup/access sequence downstream, and returns a registered response to the winner only.
- Includes an optional access timeout that aborts hung slaves with PSLVERR.

Parameters:
NUM_MASTERS, 2, number of upstream APB requesters (>=2)
APB_ADDR_WIDTH, 32, address width
APB_DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 0, max ACCESS cycles before abort; 0 disables the timeout

Ports:
clk_i  in  1  SoC clock
rst_i  in  1  synchronous reset, active-high
s_psel_i  in  NUM_MASTERS  per-master PSEL
s_penable_i  in  NUM_MASTERS  per-master PENABLE
s_pwrite_i  in  NUM_MASTERS  per-master PWRITE
s_paddr_i  in  NUM_MASTERS*APB_ADDR_WIDTH  per-master PADDR, master i at slice i
s_pwdata_i  in  NUM_MASTERS*APB_DATA_WIDTH  per-master PWDATA
s_prdata_o  out  NUM_MASTERS*APB_DATA_WIDTH  per-master PRDATA
s_pready_o  out  NUM_MASTERS  per-master PREADY
s_pslverr_o  out  NUM_MASTERS  per-master PSLVERR
m_psel_o  out  1  downstream PSEL
m_penable_o  out  1  downstream PENABLE
m_pwrite_o  out  1  downstream PWRITE
m_paddr_o  out  APB_ADDR_WIDTH  downstream PADDR
m_pwdata_o  out  APB_DATA_WIDTH  downstream PWDATA
m_prdata_i  in  APB_DATA_WIDTH  downstream PRDATA
m_pready_i  in  1  downstream PREADY
m_pslverr_i  in  1  downstream PSLVERR
busy_o  out  1  high in any state other than IDLE
timeout_o  out  1  one-cycle pulse on a timeout abort

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FSM goes to IDLE and the round-robin pointer to 0.
  - All outputs and latched registers are 0.
  - Any in-flight transfer is dropped with no response.
- All outputs are registered. No combinational path from m_* inputs to s_* outputs.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Request vector req = s_psel_i. If req != 0, choose the first set bit at or after the pointer, wrapping modulo NUM_MASTERS.
  - Latch winner index, paddr, pwdata and pwrite from the winner's slice. Go to SETUP.
- SETUP: m_psel_o=1, m_penable_o=0, address/data/write driven from the latched registers. Always go to ACCESS next cycle.
- ACCESS:
  - m_psel_o=1, m_penable_o=1. A timeout counter increments each cycle.
  - If m_pready_i=1: latch m_prdata_i (reads; 0 for writes) and m_pslverr_i, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES-1: latch prdata=0, pslverr=1, pulse timeout_o, go to RESP.
  - m_pready_i has priority over timeout in the same cycle.
- RESP:
  - m_psel_o=0, m_penable_o=0.
  - For one cycle: s_pready_o[winner]=1, s_prdata_o/s_pslverr_o of the winner's slice carry the latched values. All other masters' pready=0, prdata=0, pslverr=0.
  - Pointer becomes (winner+1) mod NUM_MASTERS, counter clears, go to IDLE.
- Latency: request sampled in IDLE at cycle 0 with a zero-wait slave gives SETUP at 1, ACCESS at 2, s_pready at 3. Each slave wait state adds 1 cycle.
- Requests are sampled only in IDLE. Losers keep PSEL/PENABLE asserted and wait; APB masters are required to hold the request until PREADY.
- Back-to-back: after RESP the FSM returns to IDLE, so there is at least 1 idle cycle between downstream transfers.
- A winner deasserting PSEL after latching does not cancel the transfer; the transfer completes downstream.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,N-1,0. No master waits more than N-1 transfers.
- The s_penable_i value is ignored for arbitration and exists for protocol completeness only.

Test Plan:
- Single master 0 write, addr 0x1A10_0004, data 0xDEAD_BEEF, zero-wait slave -> m_psel_o rises cycle 1, m_penable_o cycle 2, s_pready_o=2'b01 at cycle 3, pslverr 0.
- Masters 0 and 1 request simultaneously, reads, slave returns 0x11 then 0x22 -> master 0 served first with prdata 0x11, then master 1 with 0x22, pointer back at 0.
- Slave inserts 3 wait states on a read returning 0xCAFE_0001 with pslverr=1 -> s_pready at cycle 6, prdata 0xCAFE_0001, pslverr 1 to the winner only.
- TIMEOUT_CYCLES=8, slave never ready -> after 8 ACCESS cycles timeout_o pulses, winner gets pready=1, pslverr=1, prdata=0, FSM back in IDLE.
- Assert rst_i during ACCESS -> next cycle all outputs 0, busy_o=0. A fresh request after reset is served normally, starting with master 0.
- NUM_MASTERS=3, all requesting for 6 transfers -> grant order 0,1,2,0,1,2, never two consecutive grants to the same master.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB slave port among NUM_MASTERS requesters,
// replaying the winner's request downstream with an optional access timeout.
module apb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_MASTERS-1:0]                 s_psel_i,
  input  logic [NUM_MASTERS-1:0]                 s_penable_i,
  input  logic [NUM_MASTERS-1:0]                 s_pwrite_i,
  input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0]  s_paddr_i,
  input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0]  s_pwdata_i,
  output logic [NUM_MASTERS*APB_DATA_WIDTH-1:0]  s_prdata_o,
  output logic [NUM_MASTERS-1:0]                 s_pready_o,
  output logic [NUM_MASTERS-1:0]                 s_pslverr_o,
  output logic                                   m_psel_o,
  output logic                                   m_penable_o,
  output logic                                   m_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]              m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]              m_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]              m_prdata_i,
  input  logic                                   m_pready_i,
  input  logic                                   m_pslverr_i,
  output logic                                   busy_o,
  output logic                                   timeout_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                r_state, w_next;
  logic [IW-1:0]         r_ptr, r_win, w_win;
  logic [IW:0]           w_idx;
  logic [CW-1:0]         r_cnt;
  logic                  w_timeout, w_err, w_psel, w_penable, w_busy, w_unused;
  logic [APB_DATA_WIDTH-1:0] w_rdata;
  assign w_unused = ^s_penable_i;
  // first requester at or after the pointer, wrapping; lowest offset wins
  always_comb begin
    w_win = r_ptr;
    w_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NUM_MASTERS)) w_idx = w_idx - (IW+1)'(NUM_MASTERS);
      if (s_psel_i[w_idx[IW-1:0]]) w_win = w_idx[IW-1:0];
    end
  end
  assign w_timeout = (TIMEOUT_CYCLES != 0) && !m_pready_i && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE:    w_next = |s_psel_i ? SETUP : IDLE;
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = (m_pready_i || w_timeout) ? RESP : ACCESS;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_psel    = (w_next == SETUP) || (w_next == ACCESS);
    w_penable = w_next == ACCESS;
    w_busy    = w_next != IDLE;
    w_rdata   = (m_pready_i && !m_pwrite_o) ? m_prdata_i : '0;
    w_err     = m_pready_i ? m_pslverr_i : 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      m_psel_o    <= 1'b0;
      m_penable_o <= 1'b0;
      m_pwrite_o  <= 1'b0;
      m_paddr_o   <= '0;
      m_pwdata_o  <= '0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
      s_pready_o  <= '0;
      s_prdata_o  <= '0;
      s_pslverr_o <= '0;
    end else begin
      r_state     <= w_next;
      m_psel_o    <= w_psel;
      m_penable_o <= w_penable;
      busy_o      <= w_busy;
      timeout_o   <= 1'b0;
      s_pready_o  <= '0;
      s_prdata_o  <= '0;
      s_pslverr_o <= '0;
      if (r_state == IDLE && |s_psel_i) begin
        r_win      <= w_win;
        m_pwrite_o <= s_pwrite_i[w_win];
        m_paddr_o  <= s_paddr_i[w_win*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        m_pwdata_o <= s_pwdata_i[w_win*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
      if (r_state == ACCESS) r_cnt <= r_cnt + 1'b1;
      if (r_state == ACCESS && w_next == RESP) begin
        s_pready_o[r_win]                                 <= 1'b1;
        s_pslverr_o[r_win]                                <= w_err;
        s_prdata_o[r_win*APB_DATA_WIDTH +: APB_DATA_WIDTH] <= w_rdata;
        timeout_o                                         <= !m_pready_i;
      end
      if (r_state == RESP) begin
        r_ptr <= (r_win == IW'(NUM_MASTERS - 1)) ? '0 : r_win + 1'b1;
        r_cnt <= '0;
      end
    end
  end
endmodule
